// File: rtl/CPU_pkg.sv
// CPU_pkg: shared fetch-stage types (entry format, FSM states, trap causes).
// Rev 1.0
`default_nettype none

package CPU_pkg;

    localparam logic [31:0] CAUSE_INST_ADDR_MISALIGNED = 32'd0;
    localparam logic [31:0] CAUSE_INST_ACCESS_FAULT    = 32'd1;

    typedef enum logic [0:0] {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        exc_pend;
        logic [31:0] exc_cause;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding buffer for fetch entries; clear wins over push/pop.
// Rev 1.0
`default_nettype none

module fetch_skid_buf
    import CPU_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic         full,
    output fetch_entry_t entry
);

    logic         full_q,  full_d;
    fetch_entry_t entry_q, entry_d;

    always_comb begin
        full_d  = full_q;
        entry_d = entry_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (push) begin
            full_d  = 1'b1;
            entry_d = push_entry;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            full_q  <= full_d;
            entry_q <= entry_d;
        end
    end

    assign full  = full_q;
    assign entry = entry_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// if_stage: instruction fetch with one outstanding request, IF/ID register + skid.
// Rev 1.0
`default_nettype none

module if_stage
    import CPU_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [31:0] PC_IF,
    output logic [31:0] IR_IF,
    output logic        exc_pend_IF,
    output logic [31:0] exc_cause_IF,
    input  logic        jump_pred_IF,
    input  logic [31:0] jump_addr_IF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic         req_q, req_d;
    logic         kill_q, kill_d;
    logic         halt_q, halt_d;
    logic         out_valid_q, out_valid_d;
    fetch_entry_t out_q, out_d;

    logic         consume, pred, redirect, granted, pending, resp, launch;
    logic         new_valid, skid_full, skid_full_next, skid_push, skid_pop;
    fetch_entry_t new_entry, skid_entry;

    fetch_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect),
        .push       (skid_push),
        .push_entry (new_entry),
        .pop        (skid_pop),
        .full       (skid_full),
        .entry      (skid_entry)
    );

    always_comb begin
        consume  = out_valid_q && ready_in;
        pred     = consume && jump_pred_IF;
        redirect = flush || pred;
        granted  = (state_q == REQ) && req_q && imem_ready;
        pending  = ((state_q == WAIT) && !imem_rvalid) || ((state_q == REQ) && req_q);
        resp     = (state_q == WAIT) && imem_rvalid;

        // Entry source: bus response, or a misaligned PC trapped without a bus cycle
        new_valid = 1'b0;
        new_entry = '0;
        if (resp && !kill_q) begin
            new_valid          = 1'b1;
            new_entry.pc       = req_addr_q;
            new_entry.ir       = imem_err ? 32'd0 : imem_rdata;
            new_entry.exc_pend = imem_err;
            new_entry.exc_cause = imem_err ? CAUSE_INST_ACCESS_FAULT : 32'd0;
        end else if ((state_q == REQ) && !req_q && !halt_q && !skid_full
                     && (fetch_pc_q[1:0] != 2'b00)) begin
            new_valid           = 1'b1;
            new_entry.pc        = fetch_pc_q;
            new_entry.exc_pend  = 1'b1;
            new_entry.exc_cause = CAUSE_INST_ADDR_MISALIGNED;
        end
        if (redirect) begin
            new_valid = 1'b0;
        end

        out_valid_d = out_valid_q;
        out_d       = out_q;
        skid_push   = 1'b0;
        skid_pop    = 1'b0;
        if (redirect) begin
            out_valid_d = 1'b0;
        end else if (consume) begin
            if (skid_full) begin
                out_d     = skid_entry;
                skid_pop  = 1'b1;
                skid_push = new_valid;
            end else begin
                out_valid_d = new_valid;
                if (new_valid) out_d = new_entry;
            end
        end else if (!out_valid_q) begin
            out_valid_d = new_valid;
            if (new_valid) out_d = new_entry;
        end else begin
            skid_push = new_valid;
        end

        skid_full_next = redirect  ? 1'b0 :
                         skid_push ? 1'b1 :
                         skid_pop  ? 1'b0 : skid_full;

        halt_d = flush ? 1'b0 : (halt_q || (new_valid && new_entry.exc_pend));

        if (redirect)  kill_d = pending;
        else if (resp) kill_d = 1'b0;
        else           kill_d = kill_q;

        // A killed grant belongs to the old path, so the redirect target must not advance
        if (flush)                       fetch_pc_d = flush_addr;
        else if (pred)                   fetch_pc_d = jump_addr_IF;
        else if (granted && !kill_q)     fetch_pc_d = fetch_pc_q + 32'd4;
        else                             fetch_pc_d = fetch_pc_q;

        state_d    = state_q;
        req_d      = req_q;
        req_addr_d = req_addr_q;
        launch     = 1'b0;
        case (state_q)
            REQ: begin
                if (req_q) begin
                    if (imem_ready) begin
                        state_d = WAIT;
                        req_d   = 1'b0;
                    end
                end else begin
                    launch = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                    launch  = 1'b1;
                end
            end
            default: state_d = REQ;
        endcase
        if (launch) begin
            req_addr_d = fetch_pc_d;
            req_d      = !skid_full_next && !halt_d && (fetch_pc_d[1:0] == 2'b00);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= REQ;
            fetch_pc_q  <= RESET_ADDR;
            req_addr_q  <= 32'd0;
            req_q       <= 1'b0;
            kill_q      <= 1'b0;
            halt_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            req_q       <= req_d;
            kill_q      <= kill_d;
            halt_q      <= halt_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign valid_out    = out_valid_q;
    assign PC_IF        = out_q.pc;
    assign IR_IF        = out_q.ir;
    assign exc_pend_IF  = out_q.exc_pend;
    assign exc_cause_IF = out_q.exc_cause;
    assign imem_req     = req_q;
    assign imem_addr    = req_addr_q;

endmodule

`default_nettype wire
